// File: rtl/vector_mem_sequencer_pkg.sv
// vector_mem_sequencer_pkg: shared state type and element-size helper for the vector memory sequencer
package vector_mem_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, FAULT} vmseq_state_t;
  function automatic logic [31:0] eew_bytes(input logic [1:0] eew);
    return eew[1] ? 32'd4 : (eew[0] ? 32'd2 : 32'd1);
  endfunction
endpackage

// File: rtl/vmseq_addr_gen.sv
// vmseq_addr_gen: lane 0/1 address accumulators advancing by two elements per pair
module vmseq_addr_gen
  import vector_mem_sequencer_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        load,
  input  logic        adv,
  input  logic        strided,
  input  logic [1:0]  eew,
  input  logic [31:0] base_addr,
  input  logic [31:0] stride,
  output logic [31:0] addr0,
  output logic [31:0] addr1
);
  logic [31:0] step, step2;
  assign step = strided ? stride : eew_bytes(eew);
  // Seed both lanes on launch, then add the pair stride; wrap-around is intentional
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr0 <= '0;
      addr1 <= '0;
      step2 <= '0;
    end else if (load) begin
      addr0 <= base_addr;
      addr1 <= base_addr + step;
      step2 <= step << 1;
    end else if (adv) begin
      addr0 <= addr0 + step2;
      addr1 <= addr1 + step2;
    end
  end
endmodule

// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: walks one vector load/store through the two-lane address scheduler
module vector_mem_sequencer
  import vector_mem_sequencer_pkg::*;
#(
  parameter int VL_W = 8
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            start,
  input  logic            is_store,
  input  logic            strided,
  input  logic [1:0]      eew,
  input  logic [31:0]     base_addr,
  input  logic [31:0]     stride,
  input  logic [VL_W-1:0] vl,
  input  logic            flush,
  input  logic            fault_ack,
  output logic [31:0]     as_addr0,
  output logic [31:0]     as_addr1,
  output logic            as_load_ena,
  output logic            as_store_ena,
  output logic            as_ls_idx,
  input  logic            as_arrived0,
  input  logic            as_arrived1,
  input  logic            as_exception,
  output logic [VL_W-1:0] elem_idx,
  output logic            busy,
  output logic            done,
  output logic            fault,
  output logic [VL_W-1:0] fault_idx
);
  vmseq_state_t    state;
  logic [VL_W-1:0] vl_q;
  logic            arr0, arr1, lane0, lane1, exc, pair_done, ld;
  logic [VL_W:0]   nxt_idx;
  // Flags from the previous pair are stale in ISSUE, so only the live pulse counts there
  assign lane0     = (state == WAIT && arr0) || as_arrived0;
  assign lane1     = (state == WAIT && arr1) || as_arrived1 || !as_ls_idx;
  assign exc       = (state == ISSUE || state == WAIT) && as_exception && !flush;
  assign pair_done = state == WAIT && lane0 && lane1 && !as_exception && !flush;
  assign ld        = state == IDLE && start && !flush && vl != '0;
  assign nxt_idx   = {1'b0, elem_idx} + (VL_W+1)'(2);
  vmseq_addr_gen u_addr (
    .CLK       (CLK),
    .nRST      (nRST),
    .load      (ld),
    .adv       (pair_done),
    .strided   (strided),
    .eew       (eew),
    .base_addr (base_addr),
    .stride    (stride),
    .addr0     (as_addr0),
    .addr1     (as_addr1)
  );
  // Sequencer FSM with registered outputs; flush beats exception beats completion
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      vl_q         <= '0;
      arr0         <= 1'b0;
      arr1         <= 1'b0;
      as_load_ena  <= 1'b0;
      as_store_ena <= 1'b0;
      as_ls_idx    <= 1'b0;
      elem_idx     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      fault_idx    <= '0;
    end else if (flush) begin
      state        <= IDLE;
      as_load_ena  <= 1'b0;
      as_store_ena <= 1'b0;
      as_ls_idx    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
    end else if (exc) begin
      state        <= FAULT;
      as_load_ena  <= 1'b0;
      as_store_ena <= 1'b0;
      as_ls_idx    <= 1'b0;
      fault        <= 1'b1;
      fault_idx    <= lane0 ? elem_idx + VL_W'(1) : elem_idx;
    end else begin
      case (state)
        IDLE: if (start) begin
          vl_q     <= vl;
          elem_idx <= '0;
          busy     <= 1'b1;
          if (vl == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state        <= ISSUE;
            as_load_ena  <= !is_store;
            as_store_ena <= is_store;
            as_ls_idx    <= vl > VL_W'(1);
          end
        end
        ISSUE: begin
          arr0  <= as_arrived0;
          arr1  <= as_arrived1;
          state <= WAIT;
        end
        WAIT: begin
          arr0 <= lane0;
          arr1 <= lane1;
          if (pair_done) begin
            elem_idx <= nxt_idx[VL_W-1:0];
            if (nxt_idx >= {1'b0, vl_q}) begin
              state        <= DONE;
              as_load_ena  <= 1'b0;
              as_store_ena <= 1'b0;
              as_ls_idx    <= 1'b0;
              done         <= 1'b1;
            end else begin
              state     <= ISSUE;
              as_ls_idx <= nxt_idx + (VL_W+1)'(1) < {1'b0, vl_q};
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        FAULT: if (fault_ack) begin
          state <= IDLE;
          fault <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// tb_vector_mem_sequencer: cycle vectors plus directed corner sequences for vector_mem_sequencer
module tb_vector_mem_sequencer;
  logic        CLK = 1'b0, nRST = 1'b0;
  logic        start, is_store, strided, flush, fault_ack;
  logic [1:0]  eew;
  logic [31:0] base_addr, stride;
  logic [7:0]  vl;
  logic        as_arrived0, as_arrived1, as_exception;
  logic [31:0] as_addr0, as_addr1;
  logic        as_load_ena, as_store_ena, as_ls_idx, busy, done, fault;
  logic [7:0]  elem_idx, fault_idx;
  int checks = 0, errors = 0;

  typedef struct {
    logic        st, sto, strd;
    logic [1:0]  eew;
    logic [31:0] base, stride;
    logic [7:0]  vl;
    logic        a0, a1;
    logic        le, se, ls;
    logic [31:0] ad0, ad1;
    logic [7:0]  idx;
    logic        bsy, dn;
  } vec_t;
  vec_t tbl[18];

  vector_mem_sequencer #(.VL_W(8)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .is_store(is_store), .strided(strided),
    .eew(eew), .base_addr(base_addr), .stride(stride), .vl(vl), .flush(flush),
    .fault_ack(fault_ack), .as_addr0(as_addr0), .as_addr1(as_addr1),
    .as_load_ena(as_load_ena), .as_store_ena(as_store_ena), .as_ls_idx(as_ls_idx),
    .as_arrived0(as_arrived0), .as_arrived1(as_arrived1), .as_exception(as_exception),
    .elem_idx(elem_idx), .busy(busy), .done(done), .fault(fault), .fault_idx(fault_idx)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    {start, is_store, strided, flush, fault_ack, as_arrived0, as_arrived1, as_exception} = '0;
    eew = '0; base_addr = '0; stride = '0; vl = '0;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic sto, input logic [1:0] e, input logic [31:0] b, input logic [7:0] n);
    start = 1; is_store = sto; strided = 0; eew = e; base_addr = b; stride = 0; vl = n;
    step();
    clr();
  endtask

  function automatic logic [85:0] outs();
    return {as_load_ena, as_store_ena, as_ls_idx, as_addr0, as_addr1, elem_idx, busy, done, fault, fault_idx};
  endfunction

  initial begin
    // unit-stride load, eew=32b, vl=5, both lanes arrive together in WAIT
    tbl[0]  = '{1,0,0,2,32'h1000,0,5, 0,0, 1,0,1,32'h1000,32'h1004,0,1,0};
    tbl[1]  = '{0,0,0,0,0,0,0,          0,0, 1,0,1,32'h1000,32'h1004,0,1,0};
    tbl[2]  = '{0,0,0,0,0,0,0,          1,1, 1,0,1,32'h1008,32'h100C,2,1,0};
    tbl[3]  = '{0,0,0,0,0,0,0,          0,0, 1,0,1,32'h1008,32'h100C,2,1,0};
    tbl[4]  = '{0,0,0,0,0,0,0,          1,1, 1,0,0,32'h1010,32'h1014,4,1,0};
    tbl[5]  = '{0,0,0,0,0,0,0,          0,0, 1,0,0,32'h1010,32'h1014,4,1,0};
    tbl[6]  = '{0,0,0,0,0,0,0,          1,0, 0,0,0,32'h1018,32'h101C,6,1,1};
    tbl[7]  = '{0,0,0,0,0,0,0,          0,0, 0,0,0,32'h1018,32'h101C,6,0,0};
    // strided store, stride -8, vl=4, lane 1 lands three cycles before lane 0
    tbl[8]  = '{1,1,1,0,32'h20,32'hFFFFFFF8,4, 0,0, 0,1,1,32'h20,32'h18,0,1,0};
    tbl[9]  = '{0,0,0,0,0,0,0,          0,1, 0,1,1,32'h20,32'h18,0,1,0};
    tbl[10] = '{0,0,0,0,0,0,0,          0,0, 0,1,1,32'h20,32'h18,0,1,0};
    tbl[11] = '{0,0,0,0,0,0,0,          0,0, 0,1,1,32'h20,32'h18,0,1,0};
    tbl[12] = '{0,0,0,0,0,0,0,          1,0, 0,1,1,32'h10,32'h08,2,1,0};
    tbl[13] = '{0,0,0,0,0,0,0,          0,1, 0,1,1,32'h10,32'h08,2,1,0};
    tbl[14] = '{0,0,0,0,0,0,0,          0,0, 0,1,1,32'h10,32'h08,2,1,0};
    tbl[15] = '{0,0,0,0,0,0,0,          0,0, 0,1,1,32'h10,32'h08,2,1,0};
    tbl[16] = '{0,0,0,0,0,0,0,          1,0, 0,0,0,32'h00,32'hFFFFFFF8,4,1,1};
    tbl[17] = '{0,0,0,0,0,0,0,          0,0, 0,0,0,32'h00,32'hFFFFFFF8,4,0,0};

    clr();
    step();
    step();
    chk("reset_outputs", 128'(outs()), 128'(0));
    nRST = 1;
    step();
    chk("idle_after_reset", 128'(outs()), 128'(0));

    for (int i = 0; i < 18; i++) begin
      start = tbl[i].st; is_store = tbl[i].sto; strided = tbl[i].strd; eew = tbl[i].eew;
      base_addr = tbl[i].base; stride = tbl[i].stride; vl = tbl[i].vl;
      as_arrived0 = tbl[i].a0; as_arrived1 = tbl[i].a1;
      step();
      chk($sformatf("vec%0d", i),
          128'({as_load_ena, as_store_ena, as_ls_idx, as_addr0, as_addr1, elem_idx, busy, done, fault}),
          128'({tbl[i].le, tbl[i].se, tbl[i].ls, tbl[i].ad0, tbl[i].ad1, tbl[i].idx, tbl[i].bsy, tbl[i].dn, 1'b0}));
    end
    clr();

    // exception on lane 1 of the second pair
    launch(0, 0, 32'h100, 4);
    step();
    as_arrived0 = 1; as_arrived1 = 1; step(); clr();
    chk("exc_pair2_addrs", 128'({as_addr0, as_addr1, elem_idx}), 128'({32'h102, 32'h103, 8'd2}));
    step();
    as_arrived0 = 1; step(); clr();
    as_exception = 1; step(); clr();
    chk("exc_fault_state", 128'({fault, fault_idx, as_load_ena, as_store_ena, busy}), 128'({1'b1, 8'd3, 1'b0, 1'b0, 1'b1}));
    start = 1; base_addr = 32'h999; vl = 2; step(); clr();
    chk("fault_ignores_start", 128'({fault, busy, as_load_ena, fault_idx}), 128'({1'b1, 1'b1, 1'b0, 8'd3}));
    fault_ack = 1; step(); clr();
    chk("fault_ack_idle", 128'({fault, busy}), 128'(0));

    // exception in ISSUE before lane 0 arrives reports the lane 0 index
    launch(0, 0, 32'h0, 3);
    as_exception = 1; step(); clr();
    chk("exc_issue_lane0", 128'({fault, fault_idx, as_load_ena}), 128'({1'b1, 8'd0, 1'b0}));
    fault_ack = 1; step(); clr();

    // vl=0 completes without ever enabling the scheduler
    launch(1, 2, 32'h500, 0);
    chk("vl0_done", 128'({done, busy, as_load_ena, as_store_ena}), 128'({1'b1, 1'b1, 1'b0, 1'b0}));
    step();
    chk("vl0_done_pulse_end", 128'({done, busy, as_load_ena, as_store_ena}), 128'(0));

    // start during WAIT must not disturb the latched base or vl
    launch(0, 2, 32'h40, 2);
    step();
    start = 1; base_addr = 32'h900; vl = 8; step(); clr();
    chk("start_in_wait_ignored", 128'({as_addr0, as_addr1, as_load_ena, elem_idx}), 128'({32'h40, 32'h44, 1'b1, 8'd0}));
    as_arrived0 = 1; as_arrived1 = 1; step(); clr();
    chk("start_in_wait_done", 128'({done, elem_idx, as_addr0, as_load_ena}), 128'({1'b1, 8'd2, 32'h48, 1'b0}));
    step();

    // flush together with a completing arrival aborts without done
    launch(0, 1, 32'h200, 4);
    step();
    as_arrived0 = 1; as_arrived1 = 1; flush = 1; step(); clr();
    chk("flush_wait", 128'({busy, done, as_load_ena, elem_idx, as_addr0}), 128'({1'b0, 1'b0, 1'b0, 8'd0, 32'h200}));
    step();
    chk("flush_no_late_done", 128'({busy, done}), 128'(0));

    // flush beats start in IDLE
    start = 1; flush = 1; vl = 3; base_addr = 32'h700; step(); clr();
    chk("flush_over_start", 128'({busy, as_load_ena}), 128'(0));

    // asynchronous reset mid-ISSUE clears outputs without a clock edge
    launch(1, 2, 32'h300, 4);
    chk("pre_reset_issue", 128'({as_store_ena, busy, as_addr0}), 128'({1'b1, 1'b1, 32'h300}));
    #2 nRST = 0;
    #1 chk("async_reset", 128'(outs()), 128'(0));
    step();
    nRST = 1;
    step();

    // address wrap past 2^32
    launch(0, 2, 32'hFFFFFFFC, 2);
    chk("wrap_addrs", 128'({as_addr0, as_addr1, as_ls_idx}), 128'({32'hFFFFFFFC, 32'h0, 1'b1}));
    step();
    as_arrived0 = 1; as_arrived1 = 1; step(); clr();
    chk("wrap_done", 128'({done, elem_idx}), 128'({1'b1, 8'd2}));
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_mem_sequencer.md
Name: vector_mem_sequencer

Overview:
- Sequences one vector load/store instruction through the two-lane address scheduler, one element pair at a time.
- Walks element indices 0..vl-1 and generates the lane 0 and lane 1 addresses (unit-stride or strided).
- Drives the scheduler's load/store enables and waits for both lanes to report arrival before advancing.
- Reports done, busy or a faulting element index (vstart) back to the vector issue stage.

Parameters:
- VL_W, 8, width of vl and element index (max vl = 2^VL_W - 1).

Ports:
- CLK  input  1  clock.
- nRST  input  1  async active-low reset.
- start  input  1  one-cycle instruction launch; ignored unless state==IDLE.
- is_store  input  1  1=store, 0=load; sampled on start.
- strided  input  1  1=use stride, 0=unit-stride; sampled on start.
- eew  input  2  element width code 0=8b,1=16b,2=32b; sampled on start; 3 is treated as 2.
- base_addr  input  32  element 0 address; sampled on start.
- stride  input  32  signed byte stride; sampled on start.
- vl  input  VL_W  element count; sampled on start.
- flush  input  1  synchronous abort from any state.
- fault_ack  input  1  clears FAULT.
- as_addr0 / as_addr1  output  32  lane addresses to the scheduler.
- as_load_ena / as_store_ena  output  1  request to the scheduler.
- as_ls_idx  output  1  lane-1-valid flag to the scheduler.
- as_arrived0 / as_arrived1  input  1  per-lane completion pulses.
- as_exception  input  1  scheduler misaligned/access fault.
- elem_idx  output  VL_W  index of the current lane 0 element (VRF read/write index).
- busy  output  1  state != IDLE.
- done  output  1  one-cycle completion pulse.
- fault  output  1  high while in FAULT.
- fault_idx  output  VL_W  vstart of the faulting element.

Behaviour:
- Reset (nRST low, async): state=IDLE; all outputs 0; internal counters and flags 0.
- States: IDLE, ISSUE, WAIT, DONE, FAULT.
- IDLE + start:
  - Latch the operands.
  - vl==0 -> DONE.
  - Otherwise: elem_idx=0, as_addr0=base, as_addr1=base+step; -> ISSUE.
- step:
  - unit-stride: step = 1<<eew.
  - strided: step = stride.
  - All address arithmetic is mod 2^32. Wrap is legal and not flagged.
- ISSUE (exactly 1 cycle):
  - Assert as_load_ena (load) or as_store_ena (store).
  - as_ls_idx = (elem_idx+1 < vl).
  - Clear the lane-arrived flags. -> WAIT.
- WAIT:
  - Enables stay asserted; addresses are held stable.
  - Set arr0/arr1 flags on the as_arrived pulses. The pulses may come in any order, same cycle, or in the ISSUE cycle.
  - Lane 1 is treated as arrived when as_ls_idx==0.
  - Pair complete when arr0 & arr1 (registered flags OR current pulse):
    - elem_idx+=2, addr0+=2*step, addr1+=2*step.
    - New elem_idx >= vl -> DONE; otherwise -> ISSUE.
    - No multiplier: accumulators only.
- Exception (as_exception in ISSUE or WAIT):
  - Takes priority over pair completion in the same cycle.
  - fault_idx = elem_idx if lane 0 has not arrived, else elem_idx+1.
  - Deassert enables next cycle; -> FAULT.
- FAULT:
  - fault=1, busy=1.
  - fault_ack -> IDLE, fault cleared.
  - start is ignored.
- DONE: done=1 for one cycle, enables 0 -> IDLE.
- flush:
  - Any state -> IDLE next cycle; enables, done and fault go to 0.
  - flush wins over start, exception and completion.
- start while busy is ignored; no queueing.
- Throughput: 1 pair per 2 cycles minimum (ISSUE + WAIT with same-cycle arrival).

Decomposition:
- Package (vector types package alongside rv32i_types_pkg):
  - vmseq_state_t enum (IDLE, ISSUE, WAIT, DONE, FAULT).
  - The eew-to-byte-size function.
- Reuse width_t from rv32i_types_pkg if eew is mapped to it at the decode stage.
- One optional sub-module, vmseq_addr_gen: holds the addr0/addr1 accumulators and the step computation.
- The FSM stays in the top module.

Test Plan:
- Unit-stride load:
  - Stimulus: vl=5, eew=2, base=0x1000, arrivals same cycle.
  - Address pairs: (0x1000,0x1004), (0x1008,0x100C), (0x1010, lane1 off with as_ls_idx=0).
  - Response: done 6 cycles after ISSUE#1.
- Strided store with staggered arrivals:
  - Stimulus: stride=-8, base=0x20, vl=4; arrived1 precedes arrived0 by 3 cycles.
  - Response: addrs 0x20,0x18 then 0x10,0x08; as_store_ena held through WAIT.
- Exception on lane 1:
  - Stimulus: vl=4; the 2nd pair has arrived0 then as_exception.
  - Response: fault=1, fault_idx=3, enables low next cycle; fault_ack returns busy=0.
- vl=0 and ignored start:
  - vl=0 -> done pulse 1 cycle after start, enables never asserted.
  - start during WAIT has no effect on the latched base.
- Flush mid-WAIT plus async reset:
  - flush in the same cycle as an arrival -> IDLE, no done.
  - nRST low mid-ISSUE -> all outputs 0 immediately.
- Address wrap:
  - Stimulus: base=0xFFFFFFFC, eew=2, vl=2.
  - Response: addrs 0xFFFFFFFC and 0x00000000, done asserted.
